// File: rtl/coin_acceptor.sv
// coin_acceptor: coin-slot front end for the newspaper vending machine.
// It synchronizes and debounces three raw coin sensors. For each coin it
// produces one clean 2-bit code that is held for HOLD_CYCLES, followed by a
// forced 00 gap. A coin that arrives while the vending FSM is busy drives the
// return flap instead of being presented. If several sensors are active at
// once, the block raises jam.
// Optional build macro COIN_TALLY_EN adds a saturating running total of
// accepted coin value (tally) and a clear input (tally_clr).
//
// Handshake: there is no ready/valid pair. The consumer sees coin != 00 for
// exactly HOLD_CYCLES consecutive cycles. That run is always followed by at
// least GAP_CYCLES cycles of 00, so each nonzero run is one coin.
module coin_acceptor #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_c1,
    input  logic       sw_c2,
    input  logic       sw_c3,
    input  logic       busy,
    output logic [1:0] coin,
    output logic       coin_return,
    output logic       jam,
`ifdef COIN_TALLY_EN
    input  logic       tally_clr,
    output logic [7:0] tally,
`endif
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        PRESENT  = 3'd2,
        REJECT   = 3'd3,
        GAP      = 3'd4,
        JAM      = 3'd5
    } state_t;

    // Terminal counts. Each state exits on the cycle where its count is reached.
    localparam logic [7:0] DEB_LAST  = 8'(DEB_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LIM   = 8'(GAP_CYCLES);

    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_inc;
    logic [1:0] r_code;
    logic [1:0] w_code_nxt;
    logic [2:0] w_s;
    logic [2:0] w_cap_mask;
    logic       w_cap_hi;
    logic       w_others_hi;
    logic       w_one_hot;
    logic       w_multi;
    logic [1:0] w_coin_nxt;
    logic       w_ret_nxt;
    logic       w_jam_nxt;

    assign w_s         = r_sync2;
    assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_one_hot   = (w_s == 3'b001) || (w_s == 3'b010) || (w_s == 3'b100);
    assign w_multi     = !w_one_hot && (w_s != 3'b000);
    assign w_cap_mask  = (r_code == 2'b01) ? 3'b001 :
                         (r_code == 2'b10) ? 3'b010 :
                         (r_code == 2'b11) ? 3'b100 : 3'b000;
    assign w_cap_hi    = |(w_s & w_cap_mask);
    assign w_others_hi = |(w_s & ~w_cap_mask);
    assign o_dbg_state = r_state;

    // Two-flop synchronizers for the asynchronous sensor inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= {sw_c3, sw_c2, sw_c1};
            r_sync2 <= r_sync1;
        end
    end

    // State, counter, captured code and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_code      <= 2'b00;
            coin        <= 2'b00;
            coin_return <= 1'b0;
            jam         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_code      <= w_code_nxt;
            coin        <= w_coin_nxt;
            coin_return <= w_ret_nxt;
            jam         <= w_jam_nxt;
        end
    end

    // Next-state and counter logic; the counter restarts on every state change
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_cnt_nxt   = w_cnt_inc;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = 8'd0;
                if (w_multi) begin
                    w_state_nxt = JAM;
                end else if (w_one_hot) begin
                    w_state_nxt = DEBOUNCE;
                    w_code_nxt  = (w_s == 3'b001) ? 2'b01 :
                                  (w_s == 3'b010) ? 2'b10 : 2'b11;
                end
            end
            DEBOUNCE: begin
                if (w_others_hi) begin
                    w_state_nxt = JAM;
                end else if (!w_cap_hi) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt >= DEB_LAST) begin
                    // busy only matters on this exit cycle
                    w_state_nxt = busy ? REJECT : PRESENT;
                end
            end
            PRESENT, REJECT: begin
                if (r_cnt >= HOLD_LAST) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                // A sensor still held high keeps us here, so it never repeats
                if ((r_cnt >= GAP_LIM) && (w_s == 3'b000)) begin
                    w_state_nxt = IDLE;
                end
            end
            JAM: begin
                if (w_s != 3'b000) begin
                    w_cnt_nxt = 8'd0;
                end else if (r_cnt >= DEB_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = 8'd0;
        end
    end

    // Output decode from the next state so outputs are registered with it
    always_comb begin
        w_coin_nxt = 2'b00;
        w_ret_nxt  = 1'b0;
        w_jam_nxt  = 1'b0;
        case (w_state_nxt)
            PRESENT: w_coin_nxt = w_code_nxt;
            REJECT:  w_ret_nxt  = 1'b1;
            JAM:     w_jam_nxt  = 1'b1;
            default: ;
        endcase
    end

`ifdef COIN_TALLY_EN
    logic [8:0] w_tally_sum;
    assign w_tally_sum = {1'b0, tally} + {7'd0, r_code};

    // Running total of accepted coin value; clear beats a same-cycle add
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tally <= 8'd0;
        end else if (tally_clr) begin
            tally <= 8'd0;
        end else if ((r_state == DEBOUNCE) && (w_state_nxt == PRESENT)) begin
            tally <= w_tally_sum[8] ? 8'hFF : w_tally_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor at default parameters.
module tb_coin_acceptor;

    localparam int HOLD = 4;
    localparam int GAP  = 4;

    logic       clk;
    logic       rst;
    logic       sw_c1;
    logic       sw_c2;
    logic       sw_c3;
    logic       busy;
    logic [1:0] coin;
    logic       coin_return;
    logic       jam;
    logic [2:0] dbg_state;
`ifdef COIN_TALLY_EN
    logic       tally_clr;
    logic [7:0] tally;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard entries: {coin_return, coin}
    logic [2:0] exp_q[$];

    coin_acceptor dut (
        .clk         (clk),
        .rst         (rst),
        .sw_c1       (sw_c1),
        .sw_c2       (sw_c2),
        .sw_c3       (sw_c3),
        .busy        (busy),
        .coin        (coin),
        .coin_return (coin_return),
        .jam         (jam),
`ifdef COIN_TALLY_EN
        .tally_clr   (tally_clr),
        .tally       (tally),
`endif
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sensor(input logic [1:0] code, input logic v);
        case (code)
            2'b01:   sw_c1 = v;
            2'b10:   sw_c2 = v;
            2'b11:   sw_c3 = v;
            default: ;
        endcase
    endtask

    task automatic insert_coin(input logic [1:0] code, input int hold, input logic b);
        exp_q.push_back(b ? 3'b100 : {1'b0, code});
        busy = b;
        set_sensor(code, 1'b1);
        repeat (hold) tick();
        set_sensor(code, 1'b0);
        busy = 1'b0;
        repeat (20) tick();
    endtask

    // monitor: pops the scoreboard at each output run start, checks run shape
    logic       in_run;
    int         run_len;
    int         gap_cnt;
    logic [1:0] prev_coin;
    logic [2:0] obs_ev;
    logic [2:0] exp_ev;

    always @(negedge clk) begin
        if (!rst) begin
            in_run    = 1'b0;
            run_len   = 0;
            gap_cnt   = 255;
            prev_coin = 2'b00;
        end else begin
            obs_ev = {coin_return, coin};
            if (prev_coin != 2'b00 && coin != 2'b00 && coin != prev_coin)
                check("coin_direct_change", 8'(coin), 8'(prev_coin));
            if (obs_ev != 3'b000) begin
                if (!in_run) begin
                    in_run  = 1'b1;
                    run_len = 0;
                    check("gap_before_run", 8'(gap_cnt >= GAP), 8'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 8'(obs_ev), 8'd0);
                    end else begin
                        exp_ev = exp_q.pop_front();
                        check("out_kind", 8'(obs_ev), 8'(exp_ev));
                    end
                end
                run_len++;
            end else begin
                if (in_run) begin
                    check("hold_len", 8'(run_len), 8'(HOLD));
                    in_run  = 1'b0;
                    gap_cnt = 0;
                end
                if (gap_cnt < 255) gap_cnt++;
            end
            prev_coin = coin;
        end
    end

    // stimulus
    initial begin
        rst   = 1'b0;
        sw_c1 = 1'b0;
        sw_c2 = 1'b0;
        sw_c3 = 1'b0;
        busy  = 1'b0;
`ifdef COIN_TALLY_EN
        tally_clr = 1'b0;
`endif
        #3;
        check("rst_coin", 8'(coin), 8'd0);
        check("rst_return", 8'(coin_return), 8'd0);
        check("rst_jam", 8'(jam), 8'd0);
        check("rst_state", 8'(dbg_state), 8'd0);
`ifdef COIN_TALLY_EN
        check("rst_tally", tally, 8'd0);
`endif
        repeat (2) tick();
        rst = 1'b1;
        repeat (3) tick();

        // clean accept with latency; busy rising after the decision is ignored
        exp_q.push_back(3'b010);
        sw_c2 = 1'b1;
        repeat (6) tick();
        check("accept_edge6", 8'(coin), 8'd0);
        tick();
        check("accept_edge7", 8'(coin), 8'd2);
        busy = 1'b1;
        repeat (3) tick();
        check("accept_edge10", 8'(coin), 8'd2);
        check("accept_no_return", 8'(coin_return), 8'd0);
        tick();
        check("accept_edge11", 8'(coin), 8'd0);
        repeat (9) tick();
        sw_c2 = 1'b0;
        busy  = 1'b0;
        repeat (20) tick();

        // bounce: 1,0,1,1,0 then steady high
        exp_q.push_back(3'b001);
        sw_c1 = 1'b1; tick();
        sw_c1 = 1'b0; tick();
        sw_c1 = 1'b1; tick();
        tick();
        sw_c1 = 1'b0; tick();
        sw_c1 = 1'b1;
        repeat (6) tick();
        check("bounce_edge11", 8'(coin), 8'd0);
        tick();
        check("bounce_edge12", 8'(coin), 8'd1);
        repeat (15) tick();
        sw_c1 = 1'b0;
        repeat (20) tick();

        // reject: busy at the decision, dropped mid-return
        exp_q.push_back(3'b100);
        busy  = 1'b1;
        sw_c3 = 1'b1;
        repeat (7) tick();
        check("reject_return", 8'(coin_return), 8'd1);
        check("reject_coin", 8'(coin), 8'd0);
        tick();
        busy = 1'b0;
        repeat (3) tick();
        check("reject_end", 8'(coin_return), 8'd0);
        repeat (5) tick();
        sw_c3 = 1'b0;
        repeat (20) tick();

        // jam: two sensors together, then release
        sw_c1 = 1'b1;
        sw_c2 = 1'b1;
        repeat (3) tick();
        check("jam_set", 8'(jam), 8'd1);
        check("jam_coin", 8'(coin), 8'd0);
        repeat (5) tick();
        sw_c1 = 1'b0;
        sw_c2 = 1'b0;
        repeat (5) tick();
        check("jam_hold", 8'(jam), 8'd1);
        tick();
        check("jam_clear", 8'(jam), 8'd0);
        repeat (10) tick();

        // reset in the middle of a presentation
        exp_q.push_back(3'b010);
        sw_c2 = 1'b1;
        repeat (8) tick();
        check("midrst_pre", 8'(coin), 8'd2);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_coin", 8'(coin), 8'd0);
        check("midrst_return", 8'(coin_return), 8'd0);
        check("midrst_jam", 8'(jam), 8'd0);
        sw_c2 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (15) tick();
        check("midrst_residual", 8'(coin), 8'd0);
        check("midrst_state", 8'(dbg_state), 8'd0);

        // randomized clean coins, accepted or rejected
        for (int i = 0; i < 6; i++) begin
            insert_coin(2'($urandom_range(1, 3)), $urandom_range(7, 15), 1'($urandom_range(0, 1)));
        end

`ifdef COIN_TALLY_EN
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("tally_zero", tally, 8'd0);
        insert_coin(2'b01, 8, 1'b0);
        check("tally_1", tally, 8'd1);
        insert_coin(2'b11, 8, 1'b0);
        check("tally_4", tally, 8'd4);
        insert_coin(2'b11, 8, 1'b1);
        check("tally_reject", tally, 8'd4);
        insert_coin(2'b10, 8, 1'b0);
        check("tally_6", tally, 8'd6);
        exp_q.push_back(3'b001);
        sw_c1 = 1'b1;
        repeat (6) tick();
        tally_clr = 1'b1;
        tick();
        check("tally_clr_coin", 8'(coin), 8'd1);
        check("tally_clr_wins", tally, 8'd0);
        tally_clr = 1'b0;
        tick();
        check("tally_after_clr", tally, 8'd0);
        repeat (4) tick();
        sw_c1 = 1'b0;
        repeat (20) tick();
`endif

        check("exp_q_empty", 8'(exp_q.size()), 8'd0);
        check("no_open_run", 8'(in_run), 8'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end stage of the newspaper vending machine. Takes three raw, bouncy coin-slot sensors and produces the clean 2-bit coin code that the vending FSM consumes. Each coin appears as a nonzero code held for a fixed time, followed by a guaranteed 00 gap. Coins inserted while the vending FSM is dispensing are rejected and returned.

Parameters:
DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a sensor level (1..255)
HOLD_CYCLES, 4, cycles the coin code (or coin_return) is held asserted (1..255)
GAP_CYCLES, 4, minimum cycles coin is forced to 00 after each presentation (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset; asynchronous assert, active-low (0 = reset)
sw_c1  input  1  raw sensor, coin value 1 (code 01); asynchronous, bouncy
sw_c2  input  1  raw sensor, coin value 2 (code 10)
sw_c3  input  1  raw sensor, coin value 3 (code 11)
busy  input  1  from vending FSM paper_out; 1 = dispensing, coins not accepted
coin  output  2  clean coin code to vending FSM; 00 = no coin
coin_return  output  1  drives return flap; 1 while a rejected coin is being returned
jam  output  1  1 while more than one sensor is active (fault)

Behaviour:
- Reset (rst=0, any time, including mid-presentation): coin=00, coin_return=0, jam=0, state=IDLE, counter=0, synchronizers=0. All outputs are registered.
- Each sw_* passes through a 2-flop synchronizer. All decisions use synchronized values s1, s2, s3.
- The counter is 8 bits. It clears on every state change.
- IDLE: coin=00.
  - Exactly one s* high: capture its code, go to DEBOUNCE.
  - Two or more s* high: go to JAM.
- DEBOUNCE:
  - The captured sensor stays high with the others low for DEB_CYCLES consecutive cycles:
    - busy=0: go to PRESENT.
    - busy=1: go to REJECT.
  - The captured sensor drops: go to IDLE (glitch discarded, no output).
  - Another sensor rises: go to JAM.
- Acceptance latency: with the raw sensor clean-high from the first sampling edge (edge 1), coin takes the code at edge DEB_CYCLES+3 (edge 7 at defaults).
- busy is sampled only on the DEBOUNCE exit cycle. A later change of busy does not alter the decision.
- PRESENT: coin=captured code for exactly HOLD_CYCLES cycles, then go to GAP.
- REJECT: coin stays 00; coin_return=1 for exactly HOLD_CYCLES cycles, then go to GAP.
- GAP: coin=00, coin_return=0. Leave to IDLE only when the counter has reached GAP_CYCLES and all s* are low. A sensor held high therefore yields exactly one coin, never a repeat.
- JAM: jam=1, coin=00. Stay until all s* are low for DEB_CYCLES consecutive cycles, then go to IDLE with jam=0. No coin is credited.
- Output guarantees to the consumer:
  - coin never changes directly between two nonzero codes.
  - Every nonzero run is exactly HOLD_CYCLES long.
  - Every nonzero run is followed by at least GAP_CYCLES zeros.
- Counter saturates; it never wraps.

Optional Feature:
Macro COIN_TALLY_EN.
- Defined: adds output tally[7:0] and input tally_clr (1 bit).
  - tally adds the value (1/2/3) of each accepted coin on the PRESENT entry cycle. Rejected and jammed coins are not added.
  - tally saturates at 255.
  - tally_clr=1 sets tally to 0 on the next edge; clear wins over a simultaneous add.
  - Reset value of tally is 0.
- Undefined: the ports and register are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: rst=0 mid-PRESENT with coin=10 -> coin=00, coin_return=0, jam=0 immediately; after rst=1, no residual coin.
- Clean accept: sw_c2 high for 20 cycles, busy=0, defaults -> coin=10 from edge 7 for exactly 4 cycles, then 00; only one coin while held high.
- Bounce: sw_c1 toggles 1,0,1,1,0 per cycle then stays high -> single coin=01 presentation after the final 4+ stable samples; no earlier output.
- Reject: sw_c3 clean high, busy=1 at DEBOUNCE exit -> coin stays 00, coin_return=1 for 4 cycles, then 0.
- Jam: sw_c1 and sw_c2 high together -> jam=1, coin=00; both released -> jam=0 after 4 low samples; no coin credited.
- COIN_TALLY_EN: accept coins 01, 11, 10 -> tally=6; tally_clr together with a fourth coin's PRESENT entry -> tally=0.
